// File: rtl/hfrv_mem_arbiter_if.sv
// Shared-memory bus bundle between the CPU port, the DMA master and the memory.
// The master modport is the arbiter's view; slave is the surrounding environment.
interface hfrv_mem_arbiter_if;
  logic [31:0] cpu_address;
  logic [31:0] cpu_data_write;
  logic [3:0]  cpu_data_we;
  logic [31:0] cpu_data_read;
  logic        cpu_stall;

  logic        dma_req;
  logic [31:0] dma_address;
  logic [31:0] dma_data_write;
  logic [3:0]  dma_data_we;
  logic        dma_gnt;
  logic        dma_rvalid;
  logic [31:0] dma_data_read;

  logic [31:0] mem_address;
  logic [31:0] mem_data_write;
  logic [3:0]  mem_data_we;
  logic [31:0] mem_data_read;

  modport master (
    input  cpu_address, cpu_data_write, cpu_data_we,
    output cpu_data_read, cpu_stall,
    input  dma_req, dma_address, dma_data_write, dma_data_we,
    output dma_gnt, dma_rvalid, dma_data_read,
    output mem_address, mem_data_write, mem_data_we,
    input  mem_data_read
  );

  modport slave (
    output cpu_address, cpu_data_write, cpu_data_we,
    input  cpu_data_read, cpu_stall,
    output dma_req, dma_address, dma_data_write, dma_data_we,
    input  dma_gnt, dma_rvalid, dma_data_read,
    input  mem_address, mem_data_write, mem_data_we,
    output mem_data_read
  );
endinterface

// File: rtl/hfrv_mem_arbiter.sv
// Two-state CPU/DMA arbiter for a single shared memory port; DMA bursts are
// capped at MAX_BURST grants, after which the CPU always gets at least one cycle.
module hfrv_mem_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall_in,
  output logic [15:0]          stall_cycles,
  hfrv_mem_arbiter_if.master   bus
);

  localparam logic [0:0] CPU_OWN = 1'b0;
  localparam logic [0:0] DMA_OWN = 1'b1;
  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

  logic [0:0]  state_q, state_d;
  logic [7:0]  burst_cnt_q, burst_cnt_d;
  logic        dma_rvalid_q, dma_rvalid_d;
  logic [15:0] stall_cycles_q, stall_cycles_d;

  logic dma_own;
  logic gnt;
  logic stall;

  assign dma_own = (state_q == DMA_OWN);
  assign gnt     = dma_own && bus.dma_req;
  assign stall   = stall_in || dma_own;

  assign bus.dma_gnt        = gnt;
  assign bus.cpu_stall      = stall;
  assign bus.dma_rvalid     = dma_rvalid_q;
  assign bus.cpu_data_read  = bus.mem_data_read;
  assign bus.dma_data_read  = bus.mem_data_read;
  assign bus.mem_address    = dma_own ? bus.dma_address    : bus.cpu_address;
  assign bus.mem_data_write = dma_own ? bus.dma_data_write : bus.cpu_data_write;
  // Byte enables are masked when DMA owns the bus but is not requesting.
  assign bus.mem_data_we    = dma_own ? (bus.dma_req ? bus.dma_data_we : '0)
                                      : bus.cpu_data_we;
  assign stall_cycles       = stall_cycles_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      CPU_OWN: if (bus.dma_req) state_d = DMA_OWN;
      DMA_OWN: if (!bus.dma_req || (gnt && burst_cnt_q == BURST_LAST))
                 state_d = CPU_OWN;
      default: state_d = CPU_OWN;
    endcase
  end

  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (state_d == CPU_OWN) begin
      burst_cnt_d = '0;
    end else if (gnt) begin
      burst_cnt_d = burst_cnt_q + 8'd1;
    end
  end

  always_comb begin
    dma_rvalid_d   = gnt && (bus.dma_data_we == 4'b0000);
    stall_cycles_d = stall_cycles_q;
    if (stall && stall_cycles_q != '1) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= CPU_OWN;
      burst_cnt_q    <= '0;
      dma_rvalid_q   <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      burst_cnt_q    <= burst_cnt_d;
      dma_rvalid_q   <= dma_rvalid_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

endmodule

// File: tb/tb_hfrv_mem_arbiter.sv
// Directed bench for hfrv_mem_arbiter with a registered-read memory model.
module tb_hfrv_mem_arbiter;
  logic        clk;
  logic        reset;
  logic        stall_in;
  logic [15:0] stall_cycles;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [31:0] mem [0:255];
  logic [9:0]  gnt_pat;

  hfrv_mem_arbiter_if bus ();

  hfrv_mem_arbiter #(.MAX_BURST(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall_in     (stall_in),
    .stall_cycles (stall_cycles),
    .bus          (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: read data registered, one cycle after the address.
  always @(posedge clk) begin
    bus.mem_data_read <= mem[bus.mem_address[9:2]];
    for (int b = 0; b < 4; b++) begin
      if (bus.mem_data_we[b]) mem[bus.mem_address[9:2]][b*8 +: 8] <= bus.mem_data_write[b*8 +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h10] = 32'hCAFE0040;
    mem[8'h80] = 32'hDEADBEEF;
    bus.mem_data_read  = '0;
    bus.cpu_address    = '0;
    bus.cpu_data_write = '0;
    bus.cpu_data_we    = '0;
    bus.dma_req        = 1'b0;
    bus.dma_address    = '0;
    bus.dma_data_write = '0;
    bus.dma_data_we    = '0;
    reset    = 1'b1;
    stall_in = 1'b1;

    // Reset state
    #2;
    chk("rst_stall", bus.cpu_stall, 1'b1);
    chk("rst_gnt", bus.dma_gnt, 1'b0);
    chk("rst_rvalid", bus.dma_rvalid, 1'b0);
    chk("rst_stall_cycles", stall_cycles, 16'h0);
    stall_in = 1'b0;
    tick();
    reset = 1'b0;

    // CPU-only run
    bus.cpu_address    = 32'h100;
    bus.cpu_data_write = 32'h11223344;
    bus.cpu_data_we    = 4'hF;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("cpu_addr", bus.mem_address, 32'h100);
      chk("cpu_we", bus.mem_data_we, 4'hF);
      chk("cpu_wdata", bus.mem_data_write, 32'h11223344);
      chk("cpu_nostall", bus.cpu_stall, 1'b0);
      chk("cpu_nognt", bus.dma_gnt, 1'b0);
      tick();
    end
    bus.cpu_data_we = 4'h0;
    tick();
    chk("cpu_rdata", bus.cpu_data_read, 32'h11223344);
    chk("cpu_dma_rdata", bus.dma_data_read, 32'h11223344);

    // DMA write burst, dma_req held for 10 cycles
    bus.dma_req        = 1'b1;
    bus.dma_address    = 32'h300;
    bus.dma_data_write = 32'hA5A5A5A5;
    bus.dma_data_we    = 4'hF;
    gnt_pat = 10'b1111011110;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("burst_gnt", bus.dma_gnt, gnt_pat[i]);
      chk("burst_stall", bus.cpu_stall, gnt_pat[i]);
      chk("burst_we", bus.mem_data_we, gnt_pat[i] ? 4'hF : 4'h0);
      chk("burst_norvalid", bus.dma_rvalid, 1'b0);
      tick();
    end
    bus.dma_req = 1'b0;
    #1;
    chk("burst_stall_cycles", stall_cycles, 16'd8);
    chk("burst_end_stall", bus.cpu_stall, 1'b0);
    chk("burst_end_norvalid", bus.dma_rvalid, 1'b0);

    // Handover: CPU read of 0x40 as dma_req rises, then DMA read of 0x200
    bus.cpu_address = 32'h40;
    bus.dma_req     = 1'b1;
    bus.dma_address = 32'h200;
    bus.dma_data_we = 4'h0;
    #1;
    chk("ho_cpu_addr", bus.mem_address, 32'h40);
    chk("ho_nognt", bus.dma_gnt, 1'b0);
    tick();
    chk("ho_cpu_rdata", bus.cpu_data_read, 32'hCAFE0040);
    chk("ho_dma_addr", bus.mem_address, 32'h200);
    chk("ho_gnt", bus.dma_gnt, 1'b1);
    chk("ho_stall", bus.cpu_stall, 1'b1);
    tick();
    // dma_req drops mid-burst with a write pending: nothing may be written
    bus.dma_req        = 1'b0;
    bus.dma_address    = 32'h204;
    bus.dma_data_write = 32'h55555555;
    bus.dma_data_we    = 4'hF;
    #1;
    chk("rd_rvalid", bus.dma_rvalid, 1'b1);
    chk("rd_data", bus.dma_data_read, 32'hDEADBEEF);
    chk("drop_nognt", bus.dma_gnt, 1'b0);
    chk("drop_we", bus.mem_data_we, 4'h0);
    chk("drop_stall", bus.cpu_stall, 1'b1);
    tick();
    bus.cpu_address = 32'h204;
    #1;
    chk("drop_rvalid_clr", bus.dma_rvalid, 1'b0);
    chk("drop_cpu_own", bus.cpu_stall, 1'b0);
    chk("drop_cpu_addr", bus.mem_address, 32'h204);
    tick();
    chk("drop_nowrite", bus.cpu_data_read, 32'h0);

    // Reset pulse at the second grant of a burst
    bus.dma_req     = 1'b1;
    bus.dma_address = 32'h304;
    bus.cpu_address = 32'h3F0;
    bus.cpu_data_we = 4'h3;
    tick();
    tick();
    chk("rb_gnt2", bus.dma_gnt, 1'b1);
    reset = 1'b1;
    #1;
    chk("rb_gnt_drop", bus.dma_gnt, 1'b0);
    chk("rb_we", bus.mem_data_we, 4'h3);
    chk("rb_stall_cycles", stall_cycles, 16'h0);
    chk("rb_stall", bus.cpu_stall, 1'b0);
    tick();
    reset = 1'b0;
    #1;
    chk("rb_post_gnt", bus.dma_gnt, 1'b0);
    chk("rb_post_we", bus.mem_data_we, 4'h3);
    chk("rb_post_stall", bus.cpu_stall, 1'b0);
    bus.dma_req     = 1'b0;
    bus.cpu_data_we = 4'h0;
    tick();

    // Counter saturation with stall_in held
    stall_in = 1'b1;
    repeat (70000) @(posedge clk);
    #1;
    chk("sat_cycles", stall_cycles, 16'hFFFF);
    bus.cpu_address = 32'h44;
    #1;
    chk("sat_cpu_addr", bus.mem_address, 32'h44);
    chk("sat_stall", bus.cpu_stall, 1'b1);
    chk("sat_nognt", bus.dma_gnt, 1'b0);
    bus.dma_req     = 1'b1;
    bus.dma_address = 32'h208;
    tick();
    chk("sat_gnt", bus.dma_gnt, 1'b1);
    chk("sat_dma_addr", bus.mem_address, 32'h208);
    chk("sat_hold", stall_cycles, 16'hFFFF);
    bus.dma_req = 1'b0;
    tick();
    chk("sat_hold2", stall_cycles, 16'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hfrv_mem_arbiter.md
HFRV_MEM_ARBITER -- requirements
Module: hfrv_mem_arbiter

Interface
REQ-001 Parameter: MAX_BURST, default 4, maximum number of consecutive DMA-owned cycles before the CPU is given one cycle; legal range 1-255.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 stall_in  input  1  external stall request, OR-ed into cpu_stall.
REQ-005 cpu_address  input  32  CPU memory address.
REQ-006 cpu_data_write  input  32  CPU write data.
REQ-007 cpu_data_we  input  4  CPU byte write enables.
REQ-008 cpu_data_read  output  32  read data returned to the CPU.
REQ-009 cpu_stall  output  1  freezes the CPU pipeline.
REQ-010 dma_req  input  1  DMA master requests one transfer this cycle.
REQ-011 dma_address  input  32  DMA address.
REQ-012 dma_data_write  input  32  DMA write data.
REQ-013 dma_data_we  input  4  DMA byte enables; 0 means read.
REQ-014 dma_gnt  output  1  DMA transfer accepted this cycle.
REQ-015 dma_rvalid  output  1  dma_data_read valid, one cycle after a granted read.
REQ-016 dma_data_read  output  32  read data returned to the DMA master.
REQ-017 mem_address  output  32  shared memory address.
REQ-018 mem_data_write  output  32  shared memory write data.
REQ-019 mem_data_we  output  4  shared memory byte enables.
REQ-020 mem_data_read  input  32  memory read data, registered, valid one cycle after the address.
REQ-021 stall_cycles  output  16  saturating count of cycles with cpu_stall=1.

Function
REQ-022 The FSM SHALL have exactly two states, CPU_OWN and DMA_OWN, with a registered state.
- CPU_OWN -> DMA_OWN when dma_req=1.
- DMA_OWN -> CPU_OWN when dma_req=0, or when a grant occurs with burst_cnt=MAX_BURST-1.
- Any other condition holds the current state.
REQ-023 In CPU_OWN, mem_address, mem_data_write and mem_data_we SHALL equal the cpu_* inputs combinationally; dma_gnt=0.
REQ-024 In DMA_OWN, mem_address and mem_data_write SHALL equal the dma_* inputs.
- mem_data_we=dma_data_we when dma_req=1, otherwise 4'b0000.
REQ-025 dma_gnt SHALL equal (state==DMA_OWN && dma_req); a transfer occurs only in a cycle with dma_req=1 and dma_gnt=1.
REQ-026 cpu_stall SHALL equal stall_in OR (state==DMA_OWN), combinationally.
REQ-027 burst_cnt (8 bit) SHALL increment on each grant, clear on entering CPU_OWN, and never exceed MAX_BURST-1.
REQ-028 CPU_OWN SHALL last at least one cycle after every DMA_OWN period, so no more than MAX_BURST consecutive DMA grants occur.
REQ-029 cpu_data_read and dma_data_read SHALL both equal mem_data_read; the arbiter adds no read latency.
REQ-030 dma_rvalid SHALL be registered: 1 in the cycle after a grant with dma_data_we=0, otherwise 0.
REQ-031 A CPU access issued in the last CPU_OWN cycle SHALL return its data on cpu_data_read in the first DMA_OWN cycle, unaffected by the switch.
REQ-032 stall_in=1 SHALL NOT block DMA grants; stall_in=1 in CPU_OWN SHALL still route the bus to the CPU.
REQ-033 stall_cycles SHALL increment each cycle with cpu_stall=1 and saturate at 16'hFFFF.
REQ-034 dma_req dropping mid-burst SHALL cause no write: mem_data_we=0 that cycle, return to CPU_OWN next cycle.

Reset
REQ-035 While reset=1, asynchronously:
- state=CPU_OWN, burst_cnt=0, dma_rvalid=0, stall_cycles=0.
- Therefore dma_gnt=0 and cpu_stall=stall_in.
REQ-036 Reset asserted during DMA_OWN SHALL drop dma_gnt in the same cycle with no further memory write; the first post-reset cycle is CPU_OWN.

Verification
REQ-037 CPU-only run:
- Stimulus: dma_req=0, cpu_address=0x100, cpu_data_we=0xF.
- Response: mem_address=0x100, mem_data_we=0xF, cpu_stall=0, dma_gnt=0 throughout.
REQ-038 DMA burst with MAX_BURST=4:
- Stimulus: dma_req held 1 for 10 cycles.
- Response: grant pattern 4 on, 1 off, 4 on; cpu_stall=1 exactly in the granted cycles; stall_cycles=8.
REQ-039 DMA read:
- Stimulus: granted read at 0x200 with the memory model returning 0xDEADBEEF.
- Response: dma_rvalid=1 with dma_data_read=0xDEADBEEF one cycle later; no dma_rvalid after DMA writes.
REQ-040 Handover:
- Stimulus: CPU read at 0x40 in the cycle dma_req rises.
- Response: cpu_data_read carries 0x40's data in the next cycle; DMA owns the bus from that cycle.
REQ-041 Reset mid-burst:
- Stimulus: reset pulse at the 2nd grant.
- Response: dma_gnt=0 immediately, stall_cycles=0, mem_data_we=cpu_data_we in the first post-reset cycle.
REQ-042 Counter saturation:
- Stimulus: stall_in=1 for 70000 cycles.
- Response: stall_cycles=16'hFFFF held; DMA grants still issued while stall_in=1.
